aes128_ecb_ctrl: RTL

//  Sequencer for an iterative, one-round-per-cycle AES-128 ECB datapath.
//  - Accepts a key and starts the external key expansion.
//  - Accepts 128-bit blocks over valid/ready.
//  - Per block: drives round index, round key and mode into the round unit,

---
 rtl/aes128_ecb_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/aes128_ecb_ctrl.sv
// Purpose: sequencer for an iterative one-round-per-cycle AES-128 ECB datapath (key expansion start, round stepping, result capture).
// Latency: ke_start one cycle after key accept; out_valid rises 12 clock edges after the block-accept edge.
// Backpressure: out_valid/out_data hold until out_ready; blk_ready stays low while an unconsumed result would be overwritten.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-low reset
//   key_valid/ready/in  key handshake; an accepted key is registered onto ke_key and ke_start pulses
//   blk_valid/ready/in  block handshake; blk_decrypt selects the mode of the accepted block
//   ke_start/key/done   key-expander control; expanded_key carries RK[k] at bits [128k+127:128k]
//   rnd_*               round-unit control: load (round 0), en (rounds 1..NR), idx, final, mode, key, input block
//   rnd_dout            round-unit state, valid the cycle after the final round
//   out_valid/ready/data result handshake; blk_count counts results captured since the last key load
module aes128_ecb_ctrl #(
    parameter int NR    = 10,   // AES-128 round count; the round key table is sized from it
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [127:0]          key_in,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [127:0]          blk_in,
    input  logic                  blk_decrypt,
    output logic                  ke_start,
    output logic [127:0]          ke_key,
    input  logic                  ke_done,
    input  logic [128*(NR+1)-1:0] expanded_key,
    output logic                  rnd_load,
    output logic                  rnd_en,
    output logic [3:0]            rnd_idx,
    output logic                  rnd_final,
    output logic                  rnd_decrypt,
    output logic [127:0]          rnd_key,
    output logic [127:0]          rnd_din,
    input  logic [127:0]          rnd_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic [CNT_W-1:0]      blk_count
);

    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_KEYRDY = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_CAPT   = 3'd4;

    logic [2:0]   state;
    logic [3:0]   rnd_k;
    logic         in_round;
    logic         key_fire;
    logic         blk_fire;
    logic [3:0]   rk_sel;
    logic [127:0] rk_tbl [0:NR];

    for (genvar g = 0; g <= NR; g++) begin : g_rk
        assign rk_tbl[g] = expanded_key[128*g +: 128];
    end

    assign in_round = (state == S_ROUND);

    // key_ready is gated by reset so that every output reads 0 while reset
    // is held, even though IDLE itself advertises key_ready.
    assign key_ready = reset & ((state == S_IDLE) | (state == S_KEYRDY));

    // A pending key always wins over a block; a block is only taken when the
    // output register is empty or being popped in the same cycle.
    assign blk_ready = (state == S_KEYRDY) & ~key_valid & (~out_valid | out_ready);

    assign key_fire = key_valid & key_ready;
    assign blk_fire = blk_valid & blk_ready;

    // Decryption walks the key schedule backwards.
    assign rk_sel    = rnd_decrypt ? (NR_L - rnd_k) : rnd_k;
    assign rnd_key   = in_round ? rk_tbl[rk_sel] : '0;
    assign rnd_idx   = in_round ? rnd_k : 4'd0;
    assign rnd_load  = in_round & (rnd_k == 4'd0);
    assign rnd_en    = in_round & (rnd_k != 4'd0);
    assign rnd_final = in_round & (rnd_k == NR_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            rnd_k       <= 4'd0;
            ke_start    <= 1'b0;
            ke_key      <= '0;
            rnd_din     <= '0;
            rnd_decrypt <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            blk_count   <= '0;
        end else begin
            ke_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (key_fire) begin
                        ke_key    <= key_in;
                        ke_start  <= 1'b1;
                        blk_count <= '0;
                        state     <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    if (ke_done) begin
                        state <= S_KEYRDY;
                    end
                end
                S_KEYRDY: begin
                    if (key_fire) begin
                        ke_key    <= key_in;
                        ke_start  <= 1'b1;
                        blk_count <= '0;
                        state     <= S_KEYEXP;
                    end else if (blk_fire) begin
                        rnd_din     <= blk_in;
                        rnd_decrypt <= blk_decrypt;
                        rnd_k       <= 4'd0;
                        state       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (rnd_k == NR_L) begin
                        rnd_k <= 4'd0;
                        state <= S_CAPT;
                    end else begin
                        rnd_k <= rnd_k + 4'd1;
                    end
                end
                S_CAPT: begin
                    // rnd_dout holds the post-final-round state in this cycle.
                    out_data  <= rnd_dout;
                    blk_count <= blk_count + CNT_W'(1);
                    state     <= S_KEYRDY;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // out_valid is never high in CAPT (a block is only accepted after a
            // pop), so setting and clearing cannot collide.
            if (state == S_CAPT) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
